// File: rtl/ysyx_220066_mem_pkg.sv
// Shared MemOp encodings, FSM states and byte-lane helpers for the data-memory responder.
package ysyx_220066_mem_pkg;

    localparam logic [1:0] MOP_B = 2'd0;
    localparam logic [1:0] MOP_H = 2'd1;
    localparam logic [1:0] MOP_W = 2'd2;
    localparam logic [1:0] MOP_D = 2'd3;
    localparam int         MOP_UNSIGNED = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    // Requests reaching here are naturally aligned, so a shift by the byte offset lands the lane at bit 0.
    function automatic logic [63:0] lane_extract(input logic [63:0] word, input logic [2:0] off,
                                                 input logic [2:0] memop);
        logic [63:0] sh;
        logic        sx;
        sh = word >> {off, 3'b000};
        sx = ~memop[MOP_UNSIGNED];
        case (memop[1:0])
            MOP_B:   lane_extract = {{56{sx & sh[7]}}, sh[7:0]};
            MOP_H:   lane_extract = {{48{sx & sh[15]}}, sh[15:0]};
            MOP_W:   lane_extract = {{32{sx & sh[31]}}, sh[31:0]};
            default: lane_extract = word;
        endcase
    endfunction

    function automatic logic [7:0] wmask_of(input logic [1:0] size, input logic [2:0] off);
        case (size)
            MOP_B:   wmask_of = 8'h01 << off;
            MOP_H:   wmask_of = 8'h03 << {off[2:1], 1'b0};
            MOP_W:   wmask_of = 8'h0f << {off[2], 2'b00};
            default: wmask_of = 8'hff;
        endcase
    endfunction

    function automatic logic [63:0] merge_word(input logic [63:0] old_word, input logic [63:0] new_word,
                                               input logic [7:0] mask);
        for (int i = 0; i < 8; i++)
            merge_word[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    endfunction

endpackage

// File: rtl/ysyx_220066_sram_1rw.sv
// Single-port 64-bit SRAM: synchronous read with one-cycle latency, byte-masked write.
module ysyx_220066_sram_1rw #(
    parameter  int DEPTH = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [7:0]       wmask,
    input  logic [IDX_W-1:0] idx,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 8; i++)
                    if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/ysyx_220066_dmem_resp.sv
// CPU data-port responder: loads with lane extraction/extension, sub-dword stores via internal read-modify-write.
module ysyx_220066_dmem_resp
    import ysyx_220066_mem_pkg::*;
#(
    parameter  int          DEPTH = 1024,
    parameter  logic [63:0] BASE  = 64'h8000_0000,
    localparam int          IDX_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_memop,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    state_e           state_q, state_d;
    logic [2:0]       addr_q;
    logic [2:0]       memop_q;
    logic             wr_q;
    logic [IDX_W-1:0] idx_q;
    logic [63:0]      wdata_q;
    logic [63:0]      rdata_q;
    logic             err_q;

    logic [63:0]      offset;
    logic             misalign;
    logic             req_err;
    logic             accept;
    logic             needs_read;
    logic             sram_en;
    logic             sram_we;
    logic [IDX_W-1:0] sram_idx;
    logic [63:0]      sram_rdata;

    // Range check uses the full 64-bit offset so aliasing above the array is rejected.
    assign offset     = req_addr - BASE;
    assign misalign   = (req_addr[2:0] & ((3'b001 << req_memop[1:0]) - 3'b001)) != 3'b000;
    assign req_err    = (req_addr < BASE) || (offset >= SPAN) || misalign ||
                        (req_rd == req_wr) || (req_wr && req_memop[MOP_UNSIGNED]);
    assign accept     = req_valid && (state_q == ST_IDLE);
    assign needs_read = req_rd || (req_memop[1:0] != MOP_D);

    assign sram_en  = (accept && !req_err && needs_read) || (state_q == ST_WRITE);
    assign sram_we  = (state_q == ST_WRITE);
    assign sram_idx = (state_q == ST_IDLE) ? offset[IDX_W+2:3] : idx_q;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    ysyx_220066_sram_1rw #(.DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .wmask (8'hff),
        .idx   (sram_idx),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = req_err ? ST_RESP : (needs_read ? ST_READ : ST_WRITE);
            ST_READ:  state_d = wr_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The merged word replaces wdata_q in READ, so WRITE always stores a complete word.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            memop_q <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    addr_q  <= req_addr[2:0];
                    memop_q <= req_memop;
                    wr_q    <= req_wr;
                    idx_q   <= offset[IDX_W+2:3];
                    wdata_q <= req_wdata;
                    rdata_q <= '0;
                    err_q   <= req_err;
                end
                ST_READ: begin
                    if (wr_q)
                        wdata_q <= merge_word(sram_rdata, wdata_q << {addr_q, 3'b000},
                                              wmask_of(memop_q[1:0], addr_q));
                    else
                        rdata_q <= lane_extract(sram_rdata, addr_q, memop_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220066_dmem_resp.sv
// Directed plus randomized bench for ysyx_220066_dmem_resp against a byte-array memory model.
module tb_ysyx_220066_dmem_resp;

    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_rd, req_wr;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_memop;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mb [DEPTH*8];

    always #5 clk = ~clk;

    ysyx_220066_dmem_resp #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_memop  (req_memop),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat byte array; loads assemble bytes little-endian, then extend.
    function automatic void model(input logic rd, input logic wr, input logic [63:0] addr,
                                  input logic [2:0] mop, input logic [63:0] wd,
                                  output logic [63:0] er, output logic ee, output int lat);
        int          nb;
        logic [63:0] off;
        nb  = 1 << mop[1:0];
        off = addr - BASE;
        er  = '0;
        ee  = (addr < BASE) || (off >= SPAN) || ((addr % 64'(nb)) != 0) ||
              (rd == wr) || (wr && mop[2]);
        if (ee) begin
            lat = 1;
        end else if (rd) begin
            lat = 2;
            for (int b = 0; b < nb; b++) er |= 64'(mb[int'(off) + b]) << (8 * b);
            if (!mop[2] && nb < 8 && er[8*nb-1]) er |= ~64'd0 << (8 * nb);
        end else begin
            lat = (nb == 8) ? 2 : 3;
            for (int b = 0; b < nb; b++) mb[int'(off) + b] = 8'(wd >> (8 * b));
        end
    endfunction

    task automatic do_req(input string tag, input logic rd, input logic wr, input logic [63:0] addr,
                          input logic [2:0] mop, input logic [63:0] wd, input int bp);
        logic [63:0] er, r0;
        logic        ee;
        int          el, lat, n;
        model(rd, wr, addr, mop, wd, er, ee, el);
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, ":ready"}, 64'(req_ready), 64'd1);
        req_rd = rd; req_wr = wr; req_addr = addr; req_memop = mop; req_wdata = wd;
        req_valid = 1'b1;
        resp_ready = (bp == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check({tag, ":lat"}, 64'(lat), 64'(el));
        r0 = resp_rdata;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check({tag, ":bp_valid"}, 64'(resp_valid), 64'd1);
            check({tag, ":bp_rdata"}, resp_rdata, r0);
            check({tag, ":bp_ready"}, 64'(req_ready), 64'd0);
        end
        check({tag, ":err"}, 64'(resp_err), 64'(ee));
        check({tag, ":rdata"}, resp_rdata, er);
        resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] er;
        logic        ee;
        int          el, lat;
        logic [63:0] a;
        logic        rd, wr;

        rst = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
        req_addr = '0; req_memop = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_err",   64'(resp_err), 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);

        do_req("sd_init", 1'b0, 1'b1, BASE, 3'd3, 64'h8877_6655_4433_2211, 0);

        // sb aborted by reset while still in READ
        req_rd = 1'b0; req_wr = 1'b1; req_addr = BASE; req_memop = 3'd0; req_wdata = 64'h55;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_valid", 64'(resp_valid), 64'd0);
        check("midrst_ready", 64'(req_ready), 64'd1);
        do_req("midrst_ld", 1'b1, 1'b0, BASE, 3'd3, 64'd0, 0);

        do_req("lb7",  1'b1, 1'b0, BASE + 7, 3'd0, 64'd0, 0);
        do_req("lhu6", 1'b1, 1'b0, BASE + 6, 3'd5, 64'd0, 0);
        do_req("lw4",  1'b1, 1'b0, BASE + 4, 3'd2, 64'd0, 0);

        do_req("sh2",  1'b0, 1'b1, BASE + 2, 3'd1, 64'hABCD, 0);
        do_req("ld_a", 1'b1, 1'b0, BASE,     3'd3, 64'd0, 0);
        do_req("sb7",  1'b0, 1'b1, BASE + 7, 3'd0, 64'h00, 0);
        do_req("ld_b", 1'b1, 1'b0, BASE,     3'd3, 64'd0, 0);

        do_req("e_lh_mis",  1'b1, 1'b0, BASE + 1,        3'd1, 64'd0, 0);
        do_req("e_ld_top",  1'b1, 1'b0, BASE + SPAN,     3'd3, 64'd0, 0);
        do_req("e_lw_low",  1'b1, 1'b0, 64'h7FFF_FFFC,   3'd2, 64'd0, 0);
        do_req("e_rdwr",    1'b1, 1'b1, BASE,            3'd3, 64'hdead, 0);
        do_req("e_st_uns",  1'b0, 1'b1, BASE,            3'd4, 64'hbeef, 0);
        do_req("e_sd_top",  1'b0, 1'b1, BASE + SPAN + 8, 3'd3, 64'hbeef, 0);
        do_req("e_ld_chk",  1'b1, 1'b0, BASE,            3'd3, 64'd0, 0);

        do_req("sd_last", 1'b0, 1'b1, BASE + SPAN - 8, 3'd3, 64'h0123_4567_89ab_cdef, 0);
        do_req("lb_last", 1'b1, 1'b0, BASE + SPAN - 1, 3'd0, 64'd0, 0);

        do_req("bp_ld", 1'b1, 1'b0, BASE, 3'd3, 64'd0, 5);

        // sw then lw to the same address, req_valid held high across both
        model(1'b0, 1'b1, BASE + 4, 3'd2, 64'hCAFE_F00D, er, ee, el);
        req_rd = 1'b0; req_wr = 1'b1; req_addr = BASE + 4; req_memop = 3'd2;
        req_wdata = 64'hCAFE_F00D; req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_rd = 1'b1; req_wr = 1'b0; req_wdata = '0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("b2b_sw_lat", 64'(lat), 64'd3);
        check("b2b_sw_err", 64'(resp_err), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        model(1'b1, 1'b0, BASE + 4, 3'd2, 64'd0, er, ee, el);
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("b2b_lw_lat", 64'(lat), 64'd2);
        check("b2b_lw_rdata", resp_rdata, er);
        @(posedge clk); #1;

        for (int w = 0; w < 32; w++)
            do_req("rnd_init", 1'b0, 1'b1, BASE + 64'(w * 8), 3'd3, {$urandom, $urandom}, 0);

        for (int k = 0; k < 200; k++) begin
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 15) == 0) ? rd : ~rd;
            case ($urandom_range(0, 15))
                0:       a = BASE - 64'($urandom_range(1, 64));
                1:       a = BASE + SPAN + 64'($urandom_range(0, 64));
                default: a = BASE + 64'($urandom_range(0, 255));
            endcase
            do_req("rnd", rd, wr, a, 3'($urandom_range(0, 7)), {$urandom, $urandom},
                   ($urandom_range(0, 7) == 0) ? 2 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
